crc5_check: RTL and testbench
=============================

# crc5_check

Receive-side USB token CRC5 checker. It takes the serial token payload (7-bit address + 4-bit endpoint, LSB first) followed by the 5 received CRC bits, one bit per qualified cycle. It runs all 16 bits through the x^5+x^2+1 LFSR and flags pass/fail against the USB CRC5 residual. It sits between the receive bit-unstuffer/NRZI decoder and the token decoder, mirroring the transmit-side CRC5 generator.

## Interface
Parameters:
- RESIDUAL, 5'b01100, required LFSR contents (bit 4 = x^4 coefficient) after all 16 bits for a good packet.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  pulse; begins a new token field check (honoured only in IDLE).
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is a valid line bit this cycle.
- abort  in  1  upstream error (SE0/stuff error); discards the field in progress.
- ack  in  1  consumer has taken the result; releases HOLD.
- busy  out  1  high in SHIFT or CHECK.
- done  out  1  result valid; held until ack.
- crc_ok  out  1  residual matched; valid while done.
- crc_err  out  1  residual mismatched; valid while done.
- addr  out  7  captured address; field bits 0..6.
- endp  out  4  captured endpoint; field bits 7..10.

## Operation
- Internal state: 5-bit LFSR `s[4:0]`, 5-bit bit counter `cnt`, 11-bit field shift register `f`.
- LFSR update per accepted bit b:
  - fb = s[4]^b.
  - s <= {s[3], s[2], s[1]^fb, s[0], fb}.
- FSM states: IDLE, SHIFT, CHECK, HOLD.
- IDLE:
  - On start: s <= 5'b11111, cnt <= 0, f <= 0, addr/endp <= 0, then go to SHIFT.
  - bit_valid in the start cycle is not sampled.
- SHIFT:
  - abort has priority. On abort: go to IDLE, cnt <= 0, no done, outputs unchanged.
  - Otherwise, on bit_valid: update the LFSR, cnt <= cnt+1.
  - While cnt < 11, also shift f <= {bit_in, f[10:1]}.
  - When cnt reaches 11, f[0] holds the first bit; addr = f[6:0], endp = f[10:7], updated as f shifts.
  - Without bit_valid, hold all state (gaps of any length allowed).
  - The accepted bit with cnt == 15 (the 16th bit) moves to CHECK.
- CHECK (one cycle):
  - crc_ok <= (s == RESIDUAL), crc_err <= (s != RESIDUAL), done <= 1.
  - Go to HOLD.
  - bit_valid and abort are ignored.
- HOLD:
  - done, crc_ok, crc_err, addr, endp held stable.
  - On ack: done/crc_ok/crc_err <= 0, go to IDLE.
  - start is ignored, including when asserted together with ack; it must be re-asserted in IDLE.
  - bit_valid and abort are ignored.
- crc_ok and crc_err are never both high; both are low whenever done is low.

## Timing
- Reset values:
  - state IDLE, s = 5'b11111, cnt = 0, f = 0.
  - busy = done = crc_ok = crc_err = 0, addr = 0, endp = 0.
- Reset mid-operation returns to these values immediately (asynchronous); there is no partial result.
- Latency: the 16th bit is sampled at edge N; the state is CHECK after N; done, crc_ok and crc_err are registered high at edge N+1.
- Minimum check time is 18 cycles from the start edge (1 + 16 bits + 1 for CHECK) with continuous bit_valid.
- busy goes high on the edge after start is sampled and low at the edge that enters HOLD.
- ack is sampled only in HOLD; done falls on the edge after ack is sampled.
- An ack held high continuously has no effect outside HOLD.
- All outputs are registered; no combinational paths from inputs to outputs.

## Test plan
- Good token:
  - Stimulus: start, then 11 zeros, then 0,1,0,0,0 with continuous bit_valid.
  - Response: done=1, crc_ok=1, crc_err=0 at edge N+1; addr=0, endp=0; busy low from the same edge.
- Corrupted CRC:
  - Stimulus: same stream with the last bit flipped (11 zeros, 0,1,0,0,1).
  - Response: crc_err=1, crc_ok=0, done=1.
- Gapped input and field capture:
  - Stimulus: the good-token stream with bit_valid low for 3 cycles between every bit → crc_ok=1, done 1 cycle after the 16th valid bit.
  - Stimulus: the first 11 bits = addr 7'h15, endp 4'hA (LSB first), any CRC → addr=7'h15, endp=4'hA held through HOLD.
- Abort:
  - Stimulus: abort after 8 bits → IDLE, busy=0, no done.
  - Stimulus: then start + good-token stream → crc_ok=1 (LFSR reinitialised).
- Handshake:
  - In HOLD, start without ack → ignored, done stays 1.
  - ack+start in the same cycle → IDLE, done=0, no new check; start next cycle → new check proceeds.
- Reset mid-shift: rst_n low after 10 bits → all outputs 0 asynchronously; after release, the good-token stream gives crc_ok=1.

Source files
------------

// File: rtl/crc5_check_if.sv
// crc5_check_if: handshake and result bundle for the receive-side USB token
// CRC5 checker.
//   start     : begin a new token field check (honoured in IDLE only)
//   bit_in    : serial line bit, LSB first
//   bit_valid : bit_in carries a valid line bit this cycle
//   abort     : upstream error, discard the field in progress
//   ack       : consumer took the result, releases HOLD
//   busy      : checker in SHIFT or CHECK
//   done      : result valid, held until ack
//   crc_ok    : residual matched (valid while done)
//   crc_err   : residual mismatched (valid while done)
//   addr/endp : captured token address / endpoint
// master = upstream/consumer side, slave = checker.
interface crc5_check_if;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       abort;
    logic       ack;
    logic       busy;
    logic       done;
    logic       crc_ok;
    logic       crc_err;
    logic [6:0] addr;
    logic [3:0] endp;

    modport master (
        output start, bit_in, bit_valid, abort, ack,
        input  busy, done, crc_ok, crc_err, addr, endp
    );

    modport slave (
        input  start, bit_in, bit_valid, abort, ack,
        output busy, done, crc_ok, crc_err, addr, endp
    );
endinterface

// File: rtl/crc5_check.sv
// crc5_check: receive-side USB token CRC5 checker.
// Takes 11 payload bits (7-bit address + 4-bit endpoint, LSB first) followed
// by the 5 received CRC bits, runs all 16 through the x^5+x^2+1 LFSR and
// compares the final contents with RESIDUAL.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : crc5_check_if.slave (start/bit_in/bit_valid/abort/ack in,
//           busy/done/crc_ok/crc_err/addr/endp out)
module crc5_check #(
    parameter logic [4:0] RESIDUAL = 5'b01100
) (
    input  logic         clk,
    input  logic         rst_n,
    crc5_check_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, HOLD} state_t;

    state_t      state;
    state_t      state_nx;

    logic [4:0]  s;
    logic [4:0]  cnt;
    logic [10:0] f;
    logic [6:0]  addr_q;
    logic [3:0]  endp_q;
    logic        done_q;
    logic        ok_q;
    logic        err_q;

    logic        accept;
    logic        fb;
    logic [4:0]  s_nx;
    logic [10:0] f_nx;

    // A bit is taken only in SHIFT, and abort wins over bit_valid.
    always_comb begin
        accept = (state == SHIFT) && !bus.abort && bus.bit_valid;
        fb     = s[4] ^ bus.bit_in;
        s_nx   = {s[3], s[2], s[1] ^ fb, s[0], fb};
        f_nx   = {bus.bit_in, f[10:1]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.start) state_nx = SHIFT;
            SHIFT: begin
                if (bus.abort)                      state_nx = IDLE;
                else if (accept && cnt == 5'd15)    state_nx = CHECK;
            end
            CHECK: state_nx = HOLD;
            HOLD:  if (bus.ack) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s      <= '1;
            cnt    <= '0;
            f      <= '0;
            addr_q <= '0;
            endp_q <= '0;
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        s      <= '1;
                        cnt    <= '0;
                        f      <= '0;
                        addr_q <= '0;
                        endp_q <= '0;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        cnt <= '0;
                    end else if (bus.bit_valid) begin
                        s   <= s_nx;
                        cnt <= cnt + 5'd1;
                        // Only the 11 payload bits enter the field register;
                        // addr/endp track it so they are final after bit 11.
                        if (cnt < 5'd11) begin
                            f      <= f_nx;
                            addr_q <= f_nx[6:0];
                            endp_q <= f_nx[10:7];
                        end
                    end
                end
                CHECK: begin
                    done_q <= 1'b1;
                    ok_q   <= (s == RESIDUAL);
                    err_q  <= (s != RESIDUAL);
                end
                HOLD: begin
                    if (bus.ack) begin
                        done_q <= 1'b0;
                        ok_q   <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: all decoded from registers only
    always_comb begin
        bus.busy    = (state == SHIFT) || (state == CHECK);
        bus.done    = done_q;
        bus.crc_ok  = ok_q;
        bus.crc_err = err_q;
        bus.addr    = addr_q;
        bus.endp    = endp_q;
    end

endmodule

// File: tb/tb_crc5_check.sv
module tb_crc5_check;

    logic clk = 1'b0;
    logic rst_n;

    crc5_check_if bus();

    crc5_check #(.RESIDUAL(5'b01100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Streams, bit 0 sent first.
    // GOOD : 11 zeros then CRC 0,1,0,0,0
    // BAD  : same with last CRC bit flipped
    // FIELD: addr 7'h15, endp 4'hA, CRC bits zero
    localparam logic [15:0] GOOD  = 16'h1000;
    localparam logic [15:0] BAD   = 16'h9000;
    localparam logic [15:0] FIELD = 16'h0515;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic [31:0] busy_e, input logic [31:0] done_e,
                               input logic [31:0] ok_e, input logic [31:0] err_e);
        check({tag, ".busy"},    32'(bus.busy),    busy_e);
        check({tag, ".done"},    32'(bus.done),    done_e);
        check({tag, ".crc_ok"},  32'(bus.crc_ok),  ok_e);
        check({tag, ".crc_err"}, 32'(bus.crc_err), err_e);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Sends bits[first .. first+count-1]; inverted bit_in during gaps shows
    // that unqualified bits are not sampled.
    task automatic send_bits(input logic [15:0] bits, input int unsigned first,
                             input int unsigned count, input int unsigned gap);
        for (int unsigned i = first; i < first + count; i++) begin
            bus.bit_in    = bits[i];
            bus.bit_valid = 1'b1;
            tick();
            bus.bit_valid = 1'b0;
            if (i != 15) begin
                bus.bit_in = ~bits[i];
                repeat (gap) tick();
            end
        end
    endtask

    // After the 16th bit: CHECK for one cycle, then HOLD with result.
    task automatic expect_result(input string tag, input logic [31:0] ok_e);
        check_flags({tag, ".check"}, 1, 0, 0, 0);
        tick();
        check_flags({tag, ".hold"}, 0, 1, ok_e, 32'(!ok_e[0]));
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.abort     = 1'b0;
        bus.ack       = 1'b0;
        #12;
        check_flags("reset", 0, 0, 0, 0);
        check("reset.addr", 32'(bus.addr), 0);
        check("reset.endp", 32'(bus.endp), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Good token, continuous bits
        do_start();
        check("good.busy_after_start", 32'(bus.busy), 1);
        send_bits(GOOD, 0, 16, 0);
        expect_result("good", 1);
        check("good.addr", 32'(bus.addr), 0);
        check("good.endp", 32'(bus.endp), 0);

        // start in HOLD without ack is ignored
        do_start();
        check_flags("hold_start", 0, 1, 1, 0);
        do_ack();
        check_flags("ack", 0, 0, 0, 0);

        // Corrupted CRC
        do_start();
        send_bits(BAD, 0, 16, 0);
        expect_result("bad", 0);
        do_ack();

        // Gapped input
        do_start();
        send_bits(GOOD, 0, 16, 3);
        expect_result("gap", 1);
        do_ack();

        // Field capture, held through HOLD despite bit_valid/abort activity
        do_start();
        send_bits(FIELD, 0, 16, 0);
        tick();
        check("field.done", 32'(bus.done), 1);
        check("field.one_hot", 32'(bus.crc_ok ^ bus.crc_err), 1);
        check("field.addr", 32'(bus.addr), 'h15);
        check("field.endp", 32'(bus.endp), 'hA);
        bus.bit_valid = 1'b1;
        bus.abort     = 1'b1;
        bus.bit_in    = 1'b1;
        repeat (3) tick();
        bus.bit_valid = 1'b0;
        bus.abort     = 1'b0;
        check("field.held_done", 32'(bus.done), 1);
        check("field.held_addr", 32'(bus.addr), 'h15);
        check("field.held_endp", 32'(bus.endp), 'hA);
        do_ack();

        // Abort after 8 bits, then a fresh good check
        do_start();
        send_bits(BAD, 0, 8, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_flags("abort", 0, 0, 0, 0);
        repeat (2) tick();
        check("abort.no_done", 32'(bus.done), 0);
        do_start();
        send_bits(GOOD, 0, 16, 0);
        expect_result("after_abort", 1);

        // ack+start together: back to IDLE, start not taken
        bus.ack   = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.ack   = 1'b0;
        bus.start = 1'b0;
        check_flags("ack_start", 0, 0, 0, 0);
        tick();
        check("ack_start.idle", 32'(bus.busy), 0);
        do_start();
        check("restart.busy", 32'(bus.busy), 1);
        send_bits(GOOD, 0, 16, 0);
        expect_result("restart", 1);
        do_ack();

        // Asynchronous reset after 10 bits
        do_start();
        send_bits(FIELD, 0, 10, 0);
        check("midreset.addr_before", 32'(bus.addr), 'h2A);
        #2;
        rst_n = 1'b0;
        #1;
        check_flags("midreset", 0, 0, 0, 0);
        check("midreset.addr", 32'(bus.addr), 0);
        check("midreset.endp", 32'(bus.endp), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_start();
        send_bits(GOOD, 0, 16, 0);
        expect_result("post_reset", 1);
        do_ack();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
